branch_ctrl: RTL and testbench



---
 rtl/branch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: owns N/V/Z flags, stalls branches behind flag hazards, redirects taken branches.
// Latency: redirect/flush rise the cycle after resolution; flush held FLUSH_CYCLES cycles.
// Backpressure: combinational stall holds decode while a flag write is pending; optional stats via BRANCH_STATS_EN.
module branch_ctrl #(
    parameter int PC_W         = 16,
    parameter int OFFSET_W     = 9,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                br_valid,
    input  logic [2:0]          br_cond,
    input  logic [PC_W-1:0]     br_pc,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic                flag_pend,
    input  logic                flag_wr_en,
    input  logic [2:0]          flag_nvz,
    output logic [2:0]          nvz,
    output logic                stall,
    output logic                redirect,
    output logic [PC_W-1:0]     redirect_pc,
`ifdef BRANCH_STATS_EN
    output logic [15:0]         taken_cnt,
    output logic [15:0]         not_taken_cnt,
    output logic [15:0]         stall_cnt,
`endif
    output logic                flush
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      flush_cnt;
    logic [2:0]      eff_nvz;
    logic            taken;
    logic            resolve;
    logic [PC_W-1:0] target;

    // Evaluate the branch condition code against {N,V,Z}.
    function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'b000:  cond_met = ~z;
            3'b001:  cond_met = z;
            3'b010:  cond_met = ~z & ~n;
            3'b011:  cond_met = n;
            3'b100:  cond_met = ~n;
            3'b101:  cond_met = n | z;
            3'b110:  cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

    // A flag write in the same cycle is forwarded so the branch need not wait another cycle.
    assign eff_nvz = flag_wr_en ? flag_nvz : nvz;
    assign taken   = cond_met(br_cond, eff_nvz);
    assign target  = br_pc + {{(PC_W-OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};

    // Next-state and stall/resolve decode; branch requests are ignored while flushing.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        resolve   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (br_valid) begin
                    if (flag_pend && !flag_wr_en) begin
                        stall     = 1'b1;
                        state_nxt = ST_WAIT;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // A dropped flag_pend without a write means the older producer was squashed.
                if (flag_wr_en || !flag_pend) begin
                    resolve   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (resolve && taken) begin
            state_nxt = ST_FLUSH;
        end
        if (rst) begin
            stall   = 1'b0;
            resolve = 1'b0;
        end
    end

    // State, flag register and registered redirect/flush outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            nvz         <= 3'b000;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flush       <= 1'b0;
            flush_cnt   <= 4'd0;
        end else begin
            state    <= state_nxt;
            redirect <= 1'b0;
            if (flag_wr_en) begin
                nvz <= flag_nvz;
            end
            if (resolve && taken) begin
                redirect    <= 1'b1;
                redirect_pc <= target;
                flush       <= 1'b1;
                flush_cnt   <= FLUSH_LOAD;
            end else if (state == ST_FLUSH) begin
                if (flush_cnt == 4'd0) begin
                    flush <= 1'b0;
                end else begin
                    flush_cnt <= flush_cnt - 4'd1;
                end
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counters of branch outcomes and stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt     <= 16'd0;
            not_taken_cnt <= 16'd0;
            stall_cnt     <= 16'd0;
        end else begin
            if (resolve && taken && taken_cnt != 16'hFFFF) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
            if (resolve && !taken && not_taken_cnt != 16'hFFFF) begin
                not_taken_cnt <= not_taken_cnt + 16'd1;
            end
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed vector bench for branch_ctrl.
// Inputs change on the falling edge; stall is checked before the rising edge, registers after it.
// Stats counters are checked when BRANCH_STATS_EN is defined.
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [8:0]  br_offset;
    logic        flag_pend;
    logic        flag_wr_en;
    logic [2:0]  flag_nvz;
    logic [2:0]  nvz;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] not_taken_cnt;
    logic [15:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    branch_ctrl #(.PC_W(16), .OFFSET_W(9), .FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .br_valid(br_valid),
        .br_cond(br_cond),
        .br_pc(br_pc),
        .br_offset(br_offset),
        .flag_pend(flag_pend),
        .flag_wr_en(flag_wr_en),
        .flag_nvz(flag_nvz),
        .nvz(nvz),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
`ifdef BRANCH_STATS_EN
        .taken_cnt(taken_cnt),
        .not_taken_cnt(not_taken_cnt),
        .stall_cnt(stall_cnt),
`endif
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        bv;
        logic [2:0]  cond;
        logic [15:0] pc;
        logic [8:0]  off;
        logic        pend;
        logic        wr;
        logic [2:0]  nvz_in;
        logic        e_stall;
        logic [2:0]  e_nvz;
        logic        e_redir;
        logic [15:0] e_rpc;
        logic        e_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rs, input logic bv, input logic [2:0] cond, input logic [15:0] pc,
        input logic [8:0] off, input logic pend, input logic wr, input logic [2:0] nin,
        input logic es, input logic [2:0] en, input logic er, input logic [15:0] erpc,
        input logic ef);
        vec_t v;
        v.rst = rs; v.bv = bv; v.cond = cond; v.pc = pc; v.off = off;
        v.pend = pend; v.wr = wr; v.nvz_in = nin;
        v.e_stall = es; v.e_nvz = en; v.e_redir = er; v.e_rpc = erpc; v.e_flush = ef;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst        = v.rst;
        br_valid   = v.bv;
        br_cond    = v.cond;
        br_pc      = v.pc;
        br_offset  = v.off;
        flag_pend  = v.pend;
        flag_wr_en = v.wr;
        flag_nvz   = v.nvz_in;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #2;
        chk("stall", idx, {31'd0, stall}, {31'd0, v.e_stall});
        @(posedge clk);
        #1;
        chk("nvz", idx, {29'd0, nvz}, {29'd0, v.e_nvz});
        chk("redirect", idx, {31'd0, redirect}, {31'd0, v.e_redir});
        chk("redirect_pc", idx, {16'd0, redirect_pc}, {16'd0, v.e_rpc});
        chk("flush", idx, {31'd0, flush}, {31'd0, v.e_flush});
    endtask

    initial begin
        drive(mk(1, 0, 3'd0, 16'h0, 9'h0, 0, 0, 3'd0, 0, 3'd0, 0, 16'h0, 0));

        //          rst bv cond    pc        off     pd wr nvz_in  stl nvz    rd rpc       fl
        vecs.push_back(mk(1, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b000, 0, 16'h0000, 0)); // 0 reset
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b000, 0, 16'h0000, 0)); // 1 idle
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 1, 3'b001, 0, 3'b001, 0, 16'h0000, 0)); // 2 Z=1
        vecs.push_back(mk(0, 1, 3'd1, 16'h0010, 9'h1FC, 0, 0, 3'b000, 0, 3'b001, 1, 16'h000C, 1)); // 3 eq taken
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b001, 0, 16'h000C, 1)); // 4 flush 2nd
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b001, 0, 16'h000C, 0)); // 5 flush done
        vecs.push_back(mk(0, 1, 3'd2, 16'h0020, 9'h003, 1, 0, 3'b000, 1, 3'b001, 0, 16'h000C, 0)); // 6 hazard
        vecs.push_back(mk(0, 1, 3'd2, 16'h0020, 9'h003, 1, 0, 3'b000, 1, 3'b001, 0, 16'h000C, 0)); // 7 wait
        vecs.push_back(mk(0, 1, 3'd2, 16'h0020, 9'h003, 1, 0, 3'b000, 1, 3'b001, 0, 16'h000C, 0)); // 8 wait
        vecs.push_back(mk(0, 1, 3'd2, 16'h0020, 9'h003, 1, 1, 3'b100, 0, 3'b100, 0, 16'h000C, 0)); // 9 gt fwd N -> not taken
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b100, 0, 16'h000C, 0)); // 10 idle
        vecs.push_back(mk(0, 1, 3'd7, 16'hFFFE, 9'h005, 0, 0, 3'b000, 0, 3'b100, 1, 16'h0003, 1)); // 11 uncond wrap
        vecs.push_back(mk(0, 1, 3'd7, 16'h0100, 9'h010, 0, 0, 3'b000, 0, 3'b100, 0, 16'h0003, 1)); // 12 ignored
        vecs.push_back(mk(0, 1, 3'd7, 16'h0100, 9'h010, 0, 0, 3'b000, 0, 3'b100, 0, 16'h0003, 0)); // 13 ignored, exit
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b100, 0, 16'h0003, 0)); // 14 idle
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 1, 3'b001, 0, 3'b001, 0, 16'h0003, 0)); // 15 Z=1
        vecs.push_back(mk(0, 1, 3'd0, 16'h0040, 9'h001, 1, 0, 3'b000, 1, 3'b001, 0, 16'h0003, 0)); // 16 hazard
        vecs.push_back(mk(0, 1, 3'd0, 16'h0040, 9'h001, 0, 0, 3'b000, 0, 3'b001, 0, 16'h0003, 0)); // 17 squashed, ne not taken
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b001, 0, 16'h0003, 0)); // 18 idle
        vecs.push_back(mk(0, 1, 3'd6, 16'h0200, 9'h1FF, 1, 1, 3'b010, 0, 3'b010, 1, 16'h01FF, 1)); // 19 ov fwd taken
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b010, 0, 16'h01FF, 1)); // 20
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b010, 0, 16'h01FF, 0)); // 21
        vecs.push_back(mk(0, 1, 3'd5, 16'h0300, 9'h0FF, 0, 0, 3'b000, 0, 3'b010, 0, 16'h01FF, 0)); // 22 le not taken
        vecs.push_back(mk(0, 1, 3'd4, 16'h0300, 9'h0FF, 0, 0, 3'b000, 0, 3'b010, 1, 16'h03FF, 1)); // 23 ge taken
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 1, 3'b111, 0, 3'b111, 0, 16'h03FF, 1)); // 24 flag wr in flush
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b111, 0, 16'h03FF, 0)); // 25
        vecs.push_back(mk(0, 1, 3'd3, 16'h0500, 9'h100, 0, 0, 3'b000, 0, 3'b111, 1, 16'h0400, 1)); // 26 lt taken
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b111, 0, 16'h0400, 1)); // 27
        vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b111, 0, 16'h0400, 0)); // 28

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset asserted in the first FLUSH cycle abandons the branch.
        apply(mk(0, 1, 3'd7, 16'h0010, 9'h000, 0, 0, 3'b000, 0, 3'b111, 1, 16'h0010, 1), 100);
`ifdef BRANCH_STATS_EN
        chk("taken_cnt", 101, {16'd0, taken_cnt}, 32'd6);
        chk("not_taken_cnt", 101, {16'd0, not_taken_cnt}, 32'd3);
        chk("stall_cnt", 101, {16'd0, stall_cnt}, 32'd4);
`endif
        apply(mk(1, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b000, 0, 16'h0000, 0), 102);
`ifdef BRANCH_STATS_EN
        chk("taken_cnt_rst", 102, {16'd0, taken_cnt}, 32'd0);
`endif
        apply(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b000, 0, 16'h0000, 0), 103);
        apply(mk(0, 0, 3'd0, 16'h0000, 9'h000, 0, 0, 3'b000, 0, 3'b000, 0, 16'h0000, 0), 104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
